// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding,
// FSM state type, default datapath width and op-class decode helpers.
// Optional feature macro: MDU_MADD_EN (ops 110/111 become MADD/MADDU).
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mduStateT;

    // Ops that run the shift-add multiply sequence.
    function automatic logic opIsMul(input logic [2:0] opCode);
`ifdef MDU_MADD_EN
        return (opCode == OP_MULT) || (opCode == OP_MULTU) ||
               (opCode == OP_MADD) || (opCode == OP_MADDU);
`else
        return (opCode == OP_MULT) || (opCode == OP_MULTU);
`endif
    endfunction

    function automatic logic opIsDiv(input logic [2:0] opCode);
        return (opCode == OP_DIV) || (opCode == OP_DIVU);
    endfunction

    // Ops whose operands are treated as two's-complement.
    function automatic logic opIsSigned(input logic [2:0] opCode);
`ifdef MDU_MADD_EN
        return (opCode == OP_MULT) || (opCode == OP_DIV) || (opCode == OP_MADD);
`else
        return (opCode == OP_MULT) || (opCode == OP_DIV);
`endif
    endfunction

    function automatic logic opIsMove(input logic [2:0] opCode);
        return (opCode == OP_MTHI) || (opCode == OP_MTLO);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the iterative multiply/divide datapath.
// divMode=0: shift-add multiply step on {accHi,accLo}, multiplier in accLo.
// divMode=1: restoring divide step, remainder in accHi, dividend/quotient in accLo.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             divMode,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] stepHi,
    output logic [WIDTH-1:0] stepLo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // Trial subtraction only needs the low bits: when the divisor fits, the
    // true difference is below the divisor and therefore below 2^WIDTH.
    always_comb begin
        sum     = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
        shifted = {accHi, accLo[WIDTH-1]};
        trial   = shifted[WIDTH-1:0] - opB;
        fits    = (shifted >= {1'b0, opB});
        stepHi  = '0;
        stepLo  = '0;
        if (divMode) begin
            stepHi = fits ? trial : shifted[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], fits};
        end else begin
            {stepHi, stepLo} = {sum, accLo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit. Holds the architectural HI/LO
// registers and sequences MULT/MULTU/DIV/DIVU over WIDTH clocks.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU accumulate into HI/LO.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here in one edge
// RUN   | one multiply/divide iteration per clock, WIDTH clocks
// FIX   | sign fix-up; HI/LO written on the edge leaving this state
// DONE  | result visible, done pulse; a new start is accepted here
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mduStateT         state, nextState;
    logic [CW-1:0]    iterCnt;
    logic [2:0]       opReg;
    logic             negResult, negRem, dbzFlag;
    logic [WIDTH-1:0] accHi, accLo, opB;
    logic [WIDTH-1:0] hiReg, loReg;
    logic [WIDTH-1:0] stepHi, stepLo;
    logic [WIDTH-1:0] resHi, resLo;
    logic             accept, opValid, isArith, divZeroIn;
    logic             aNeg, bNeg;
    logic [WIDTH-1:0] absA, absB;
    logic [2*WIDTH-1:0] product, signedProd;
    logic [WIDTH-1:0] quot, rem;

    assign isArith   = opIsMul(op) || opIsDiv(op);
    assign opValid   = isArith || opIsMove(op);
    assign divZeroIn = opIsDiv(op) && (rt_data == '0);
    assign aNeg      = opIsSigned(op) && rs_data[WIDTH-1];
    assign bNeg      = opIsSigned(op) && rt_data[WIDTH-1];
    assign absA      = aNeg ? -rs_data : rs_data;
    assign absB      = bNeg ? -rt_data : rt_data;

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .divMode (opIsDiv(opReg)),
        .accHi   (accHi),
        .accLo   (accLo),
        .opB     (opB),
        .stepHi  (stepHi),
        .stepLo  (stepLo)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state, acceptance and status outputs.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done      = (state == DONE);
                nextState = IDLE;
                if (start && opValid) begin
                    accept = 1'b1;
                    if (isArith) nextState = divZeroIn ? FIX : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (iterCnt == CW'(WIDTH-1)) nextState = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                nextState = DONE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Final HI/LO values computed from the iteration registers in FIX.
    always_comb begin
        product    = {accHi, accLo};
        signedProd = negResult ? -product : product;
        quot       = negResult ? -accLo : accLo;
        rem        = negRem ? -accHi : accHi;
        resHi      = hiReg;
        resLo      = loReg;
        if (dbzFlag) begin
            resHi = accHi;
            resLo = accLo;
        end else if (opIsDiv(opReg)) begin
            resHi = rem;
            resLo = quot;
        end
`ifdef MDU_MADD_EN
        else if ((opReg == OP_MADD) || (opReg == OP_MADDU)) begin
            {resHi, resLo} = {hiReg, loReg} + signedProd;
        end
`endif
        else begin
            {resHi, resLo} = signedProd;
        end
    end

    // Operand capture, iteration and HI/LO update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iterCnt   <= '0;
            opReg     <= OP_MULT;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            dbzFlag   <= 1'b0;
            accHi     <= '0;
            accLo     <= '0;
            opB       <= '0;
            hiReg     <= '0;
            loReg     <= '0;
        end else if (accept) begin
            opReg     <= op;
            iterCnt   <= '0;
            dbzFlag   <= divZeroIn;
            negResult <= aNeg ^ bNeg;
            negRem    <= aNeg;
            if (op == OP_MTHI) hiReg <= rs_data;
            if (op == OP_MTLO) loReg <= rs_data;
            if (divZeroIn) begin
                accHi <= rs_data;
                accLo <= '1;
            end else if (isArith) begin
                accHi <= '0;
                accLo <= absA;
                opB   <= absB;
            end
        end else if (state == RUN) begin
            accHi   <= stepHi;
            accLo   <= stepLo;
            iterCnt <= iterCnt + 1'b1;
        end else if (state == FIX) begin
            hiReg <= resHi;
            loReg <= resLo;
        end
    end

    assign div_by_zero = dbzFlag;
    assign hi          = hiReg;
    assign lo          = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_data, rt_data;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    int nCyc;
    int pulses;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one start for a single cycle; returns at the falling edge after
    // the accepting edge with the operand inputs scrambled.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        op      = OP_MTHI;
        rs_data = 32'hDEAD_BEEF;
        rt_data = 32'h1234_5678;
    endtask

    // Count falling edges until done is seen, bounded.
    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        op      = OP_MULT;
        rs_data = '0;
        rt_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz",  div_by_zero, 0);
        check("rst_hilo", {hi, lo}, 64'h0);
        reset = 1'b1;

        // MULT -3 * 7
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_busy", busy, 1);
        waitDone(nCyc);
        check("mult_lat", nCyc, 33);
        check("mult_busy_done", busy, 0);
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        check("mult_done_width", done, 0);

        // MULTU max * max
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(nCyc);
        check("multu_lat", nCyc, 33);
        check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // DIV -7 / 2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone(nCyc);
        check("div_lat", nCyc, 33);
        check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIV 7 / -2 : quotient -3, remainder +1
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        waitDone(nCyc);
        check("div_negdiv", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        // DIV overflow: 0x80000000 / -1
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(nCyc);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        // DIVU 22 / 5, then MTHI accepted in the DONE cycle
        issue(OP_DIVU, 32'd22, 32'd5);
        waitDone(nCyc);
        check("divu_hilo", {hi, lo}, 64'h0000_0002_0000_0004);
        start   = 1'b1;
        op      = OP_MTHI;
        rs_data = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_hi", hi, 32'h0000_1234);
        check("start_in_done_lo", lo, 32'd4);
        check("mthi_no_busy", busy, 0);
        check("mthi_no_done", done, 0);

        // DIVU by zero
        issue(OP_DIVU, 32'd10, 32'd0);
        waitDone(nCyc);
        check("dbz_lat", nCyc, 1);
        check("dbz_hilo", {hi, lo}, 64'h0000_000A_FFFF_FFFF);
        check("dbz_flag", div_by_zero, 1);
        @(negedge clk);
        check("dbz_sticky", div_by_zero, 1);
        issue(OP_MTLO, 32'd0, 32'd0);
        check("dbz_clear", div_by_zero, 0);
        check("mtlo_lo", lo, 32'd0);

        // Fresh state, then MULT 20*40 with an ignored MTHI mid-run
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        issue(OP_MULT, 32'd20, 32'd40);
        repeat (4) @(negedge clk);
        start   = 1'b1;
        op      = OP_MTHI;
        rs_data = 32'h55;
        @(negedge clk);
        start = 1'b0;
        check("ignored_hi_now", hi, 32'h0);
        check("ignored_busy", busy, 1);
        waitDone(nCyc);
        check("ignored_done_seen", done, 1);
        check("ignored_hilo", {hi, lo}, 64'h0000_0000_0000_0320);

        // Reset mid-operation aborts with no done pulse
        issue(OP_MULT, 32'd20, 32'd40);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_hilo_after", {hi, lo}, 64'h0);

        // Accumulate op (or NOP without the feature)
        issue(OP_MTLO, 32'd5, 32'd0);
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MADD, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        waitDone(nCyc);
        check("madd_lat", nCyc, 33);
        check("madd_hilo", {hi, lo}, 64'h0000_0000_0000_0011);
`else
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        check("nop_no_activity", pulses, 0);
        check("nop_hilo", {hi, lo}, 64'h0000_0000_0000_0005);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
